// File: rtl/rc4_prga_decrypt_if.sv
`timescale 1ns/1ps
// rc4_prga_decrypt_if
// Bundles the controller handshake and the three memory ports of the RC4
// keystream/decrypt stage.
//   start_task2b      controller -> stage   level start request
//   task2b_done_flag  stage -> controller   high while the stage sits in DONE
//   s_address/s_data/s_wren, s_q            S memory port (synchronous read)
//   rom_address, rom_q                      encrypted-message ROM (synchronous read)
//   dec_address/dec_data/dec_wren           decrypted-message RAM write port
// modport slave  : the decrypt stage itself
// modport master : the surrounding controller plus memories
interface rc4_prga_decrypt_if #(
    parameter int MSG_AW = 5
);
    logic              start_task2b;
    logic              task2b_done_flag;
    logic [7:0]        s_q;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        rom_q;
    logic [MSG_AW-1:0] rom_address;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;

    modport slave (
        input  start_task2b, s_q, rom_q,
        output task2b_done_flag, s_address, s_data, s_wren,
               rom_address, dec_address, dec_data, dec_wren
    );

    modport master (
        output start_task2b, s_q, rom_q,
        input  task2b_done_flag, s_address, s_data, s_wren,
               rom_address, dec_address, dec_data, dec_wren
    );
endinterface

// File: rtl/rc4_prga_decrypt.sv
`timescale 1ns/1ps
// rc4_prga_decrypt
// RC4 pseudo-random generation over an already key-scheduled S memory. Each
// keystream byte is XORed with the encrypted ROM and the plaintext is written
// to the decrypted RAM. One byte takes 12 cycles; every memory read is a
// three-cycle drive/hold/sample sequence because the memories have a
// registered read port.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous, active-low reset (aborts a run; memories untouched)
//   bus    rc4_prga_decrypt_if.slave - start/done handshake, S port,
//          encrypted ROM port, decrypted RAM port
// All outputs are registered: each state's outputs are loaded on the edge
// that enters that state, so addresses are stable through the hold states.
module rc4_prga_decrypt #(
    parameter int MSG_LEN = 32,
    parameter int MSG_AW  = 5
) (
    input  logic                clk,
    input  logic                reset,
    rc4_prga_decrypt_if.slave   bus
);

    typedef enum logic [3:0] {
        IDLE, RD_I, WT_I, LT_I, RD_J, WT_J, LT_J,
        WR_I, WR_J, RD_F, WT_F, LT_F, WR_D, DONE
    } state_t;

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

    state_t            state_q;
    logic [7:0]        i_q, j_q, si_q, sj_q, f_q;
    logic [MSG_AW-1:0] k_q;
    logic [7:0]        s_address_q, s_data_q, dec_data_q;
    logic              s_wren_q, dec_wren_q, done_q;
    logic [MSG_AW-1:0] rom_address_q, dec_address_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            f_q           <= '0;
            s_address_q   <= '0;
            s_data_q      <= '0;
            s_wren_q      <= 1'b0;
            rom_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_wren_q    <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            // Write enables are single-cycle pulses; only the states that
            // precede a write state raise them again.
            s_wren_q   <= 1'b0;
            dec_wren_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    i_q    <= '0;
                    j_q    <= '0;
                    k_q    <= '0;
                    done_q <= 1'b0;
                    if (bus.start_task2b) begin
                        // i is 0 here, so the first read is S[1].
                        s_address_q <= 8'd1;
                        state_q     <= RD_I;
                    end else begin
                        s_address_q <= '0;
                    end
                end
                RD_I: begin
                    i_q     <= i_q + 8'd1;
                    state_q <= WT_I;
                end
                WT_I: state_q <= LT_I;
                LT_I: begin
                    si_q        <= bus.s_q;
                    j_q         <= j_q + bus.s_q;
                    s_address_q <= j_q + bus.s_q;
                    state_q     <= RD_J;
                end
                RD_J: state_q <= WT_J;
                WT_J: state_q <= LT_J;
                LT_J: begin
                    // Swap: S[i] <= S[j] first, then S[j] <= S[i]. When i==j
                    // both writes carry the same value, leaving S unchanged.
                    sj_q        <= bus.s_q;
                    s_address_q <= i_q;
                    s_data_q    <= bus.s_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= WR_I;
                end
                WR_I: begin
                    s_address_q <= j_q;
                    s_data_q    <= si_q;
                    s_wren_q    <= 1'b1;
                    state_q     <= WR_J;
                end
                WR_J: begin
                    s_address_q   <= si_q + sj_q;
                    s_data_q      <= '0;
                    rom_address_q <= k_q;
                    state_q       <= RD_F;
                end
                RD_F: state_q <= WT_F;
                WT_F: state_q <= LT_F;
                LT_F: begin
                    // rom_q and s_q are both valid now; the XOR is registered
                    // so dec_data equals f ^ rom_q throughout WR_D.
                    f_q           <= bus.s_q;
                    dec_address_q <= k_q;
                    dec_data_q    <= bus.s_q ^ bus.rom_q;
                    dec_wren_q    <= 1'b1;
                    state_q       <= WR_D;
                end
                WR_D: begin
                    if (k_q == K_LAST) begin
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        k_q         <= k_q + MSG_AW'(1);
                        s_address_q <= i_q + 8'd1;
                        state_q     <= RD_I;
                    end
                end
                DONE: begin
                    // Stay here until start drops, so a held start cannot
                    // retrigger a second run.
                    if (!bus.start_task2b) begin
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.s_address        = s_address_q;
    assign bus.s_data           = s_data_q;
    assign bus.s_wren           = s_wren_q;
    assign bus.rom_address      = rom_address_q;
    assign bus.dec_address      = dec_address_q;
    assign bus.dec_data         = dec_data_q;
    assign bus.dec_wren         = dec_wren_q;
    assign bus.task2b_done_flag = done_q;

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
`timescale 1ns/1ps
// Bench for rc4_prga_decrypt: a 3-byte instance for the directed scenarios
// and a 32-byte instance for the full-length decrypt against a reference model.
module tb_rc4_prga_decrypt;
    localparam int AW = 5;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    rc4_prga_decrypt_if #(.MSG_AW(AW)) ifa ();
    rc4_prga_decrypt_if #(.MSG_AW(AW)) ifb ();

    rc4_prga_decrypt #(.MSG_LEN(3), .MSG_AW(AW)) dut_a (
        .clk(clk), .reset(reset), .bus(ifa.slave));
    rc4_prga_decrypt #(.MSG_LEN(32), .MSG_AW(AW)) dut_b (
        .clk(clk), .reset(reset), .bus(ifb.slave));

    int n_checks = 0;
    int n_fail   = 0;

    // Preload images copied into the memories on a load pulse.
    logic [7:0] s_init [256];
    logic [7:0] rom_init [32];
    logic [7:0] exp_full [32];
    logic [7:0] exp_s_full [256];
    logic       ld_a = 1'b0;
    logic       ld_b = 1'b0;

    // Memories and write monitor for instance A.
    logic [7:0] s_a [256];
    logic [7:0] rom_a [32];
    logic [7:0] dec_a [32];
    logic [7:0] wl_addr [16];
    logic [7:0] wl_data [16];
    int wcnt_a = 0, dcnt_a = 0, both_a = 0;

    always @(posedge clk) begin
        if (ld_a) begin
            for (int n = 0; n < 256; n++) s_a[n] <= s_init[n];
            for (int n = 0; n < 32; n++) begin
                rom_a[n] <= rom_init[n];
                dec_a[n] <= 8'hEE;
            end
            wcnt_a <= 0;
            dcnt_a <= 0;
            both_a <= 0;
        end else begin
            if (ifa.s_wren) begin
                s_a[ifa.s_address] <= ifa.s_data;
                if (wcnt_a < 16) begin
                    wl_addr[wcnt_a] <= ifa.s_address;
                    wl_data[wcnt_a] <= ifa.s_data;
                end
                wcnt_a <= wcnt_a + 1;
            end
            if (ifa.dec_wren) begin
                dec_a[ifa.dec_address] <= ifa.dec_data;
                dcnt_a <= dcnt_a + 1;
            end
            if (ifa.s_wren && ifa.dec_wren) both_a <= both_a + 1;
        end
        ifa.s_q   <= s_a[ifa.s_address];
        ifa.rom_q <= rom_a[ifa.rom_address];
    end

    // Memories for instance B.
    logic [7:0] s_b [256];
    logic [7:0] rom_b [32];
    logic [7:0] dec_b [32];
    int dcnt_b = 0;

    always @(posedge clk) begin
        if (ld_b) begin
            for (int n = 0; n < 256; n++) s_b[n] <= s_init[n];
            for (int n = 0; n < 32; n++) begin
                rom_b[n] <= rom_init[n];
                dec_b[n] <= 8'hEE;
            end
            dcnt_b <= 0;
        end else begin
            if (ifb.s_wren) s_b[ifb.s_address] <= ifb.s_data;
            if (ifb.dec_wren) begin
                dec_b[ifb.dec_address] <= ifb.dec_data;
                dcnt_b <= dcnt_b + 1;
            end
        end
        ifb.s_q   <= s_b[ifb.s_address];
        ifb.rom_q <= rom_b[ifb.rom_address];
    end

    task automatic setup_small(input logic [7:0] r0, input logic [7:0] r1, input logic [7:0] r2);
        for (int n = 0; n < 256; n++) s_init[n] = 8'(n);
        for (int n = 0; n < 32; n++) rom_init[n] = 8'h00;
        rom_init[0] = r0;
        rom_init[1] = r1;
        rom_init[2] = r2;
        @(negedge clk); ld_a = 1'b1;
        @(negedge clk); ld_a = 1'b0;
    endtask

    // Waits (bounded) for the done flag; cycles counts negedges after the
    // first one, i.e. clock edges after the one sampling start.
    task automatic wait_done(input bit sel, input int bound, output int cycles);
        cycles = 0;
        @(negedge clk);
        while (((sel ? ifb.task2b_done_flag : ifa.task2b_done_flag) !== 1'b1) && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
    endtask

    task automatic end_run_a();
        @(negedge clk); ifa.start_task2b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++; if (ifa.task2b_done_flag !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", ifa.task2b_done_flag); end
        n_checks++; if (ifa.s_wren !== 1'b0) begin n_fail++; $display("FAIL reset_s_wren: got %b want 0", ifa.s_wren); end
        n_checks++; if (ifa.dec_wren !== 1'b0) begin n_fail++; $display("FAIL reset_dec_wren: got %b want 0", ifa.dec_wren); end
        n_checks++; if (ifa.s_address !== 8'h00) begin n_fail++; $display("FAIL reset_s_address: got %h want 00", ifa.s_address); end
        n_checks++; if ({ifa.s_data, ifa.dec_data, ifa.rom_address, ifa.dec_address} !== '0) begin
            n_fail++; $display("FAIL reset_data_addr: got %h %h %h %h want all 0", ifa.s_data, ifa.dec_data, ifa.rom_address, ifa.dec_address); end
        n_checks++; if (ifb.task2b_done_flag !== 1'b0 || ifb.s_wren !== 1'b0 || ifb.dec_wren !== 1'b0) begin
            n_fail++; $display("FAIL reset_b_outputs: got %b%b%b want 000", ifb.task2b_done_flag, ifb.s_wren, ifb.dec_wren); end
        @(negedge clk); reset = 1'b1;
        repeat (2) @(negedge clk);
        $display("reset: outputs checked");
    endtask

    task automatic test_identity_zero_rom();
        logic [7:0] exp [3];
        int cyc, bad;
        exp = '{8'h02, 8'h05, 8'h07};
        setup_small(8'h00, 8'h00, 8'h00);
        ifa.start_task2b = 1'b1;
        wait_done(1'b0, 200, cyc);
        n_checks++; if (ifa.task2b_done_flag !== 1'b1) begin n_fail++; $display("FAIL ident_done: got %b want 1 (timeout)", ifa.task2b_done_flag); end
        for (int n = 0; n < 3; n++) begin
            n_checks++; if (dec_a[n] !== exp[n]) begin n_fail++; $display("FAIL ident_dec[%0d]: got %h want %h", n, dec_a[n], exp[n]); end
        end
        n_checks++; if (s_a[2] !== 8'h03) begin n_fail++; $display("FAIL ident_S2: got %h want 03", s_a[2]); end
        n_checks++; if (s_a[3] !== 8'h05) begin n_fail++; $display("FAIL ident_S3: got %h want 05", s_a[3]); end
        n_checks++; if (s_a[5] !== 8'h02) begin n_fail++; $display("FAIL ident_S5: got %h want 02", s_a[5]); end
        bad = 0;
        for (int n = 0; n < 256; n++)
            if (n != 2 && n != 3 && n != 5 && s_a[n] !== 8'(n)) bad++;
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL ident_S_others: got %0d changed entries want 0", bad); end
        n_checks++; if (wcnt_a != 6 || dcnt_a != 3) begin n_fail++; $display("FAIL ident_write_counts: got s=%0d dec=%0d want s=6 dec=3", wcnt_a, dcnt_a); end
        n_checks++; if (both_a != 0) begin n_fail++; $display("FAIL ident_wren_overlap: got %0d cycles want 0", both_a); end
        $display("run identity/zero ROM: dec=%h %h %h", dec_a[0], dec_a[1], dec_a[2]);
    endtask

    // Uses the write log of the identity run: byte 0 has i=j=1.
    task automatic test_i_eq_j();
        n_checks++; if (wl_addr[0] !== 8'h01 || wl_data[0] !== 8'h01) begin n_fail++; $display("FAIL ieqj_write0: got S[%h]<=%h want S[01]<=01", wl_addr[0], wl_data[0]); end
        n_checks++; if (wl_addr[1] !== 8'h01 || wl_data[1] !== 8'h01) begin n_fail++; $display("FAIL ieqj_write1: got S[%h]<=%h want S[01]<=01", wl_addr[1], wl_data[1]); end
        n_checks++; if (s_a[1] !== 8'h01) begin n_fail++; $display("FAIL ieqj_S1: got %h want 01", s_a[1]); end
        $display("i==j: writes S[%h]<=%h, S[%h]<=%h", wl_addr[0], wl_data[0], wl_addr[1], wl_data[1]);
        end_run_a();
    endtask

    task automatic test_latency_rom();
        logic [7:0] exp [3];
        int cyc;
        exp = '{8'h43, 8'h47, 8'h44};
        setup_small(8'h41, 8'h42, 8'h43);
        ifa.start_task2b = 1'b1;
        wait_done(1'b0, 200, cyc);
        n_checks++; if (cyc != 36 || ifa.task2b_done_flag !== 1'b1) begin n_fail++; $display("FAIL latency: got %0d cycles (flag %b) want 36", cyc, ifa.task2b_done_flag); end
        for (int n = 0; n < 3; n++) begin
            n_checks++; if (dec_a[n] !== exp[n]) begin n_fail++; $display("FAIL rom_dec[%0d]: got %h want %h", n, dec_a[n], exp[n]); end
        end
        $display("run ROM 41/42/43: latency=%0d dec=%h %h %h", cyc, dec_a[0], dec_a[1], dec_a[2]);
    endtask

    // Continues from the completed latency run with start still high.
    task automatic test_handshake();
        logic [7:0] exp [3];
        int w0, d0, low, cyc;
        exp = '{8'h02, 8'h05, 8'h07};
        w0 = wcnt_a; d0 = dcnt_a; low = 0;
        repeat (5) begin
            @(negedge clk);
            if (ifa.task2b_done_flag !== 1'b1) low++;
        end
        n_checks++; if (low != 0) begin n_fail++; $display("FAIL hs_flag_hold: got %0d low cycles want 0", low); end
        n_checks++; if (wcnt_a != w0 || dcnt_a != d0) begin n_fail++; $display("FAIL hs_no_writes: got s=%0d dec=%0d want s=%0d dec=%0d", wcnt_a, dcnt_a, w0, d0); end
        ifa.start_task2b = 1'b0;
        @(negedge clk);
        n_checks++; if (ifa.task2b_done_flag !== 1'b0) begin n_fail++; $display("FAIL hs_flag_fall: got %b want 0", ifa.task2b_done_flag); end
        setup_small(8'h00, 8'h00, 8'h00);
        ifa.start_task2b = 1'b1;
        wait_done(1'b0, 200, cyc);
        n_checks++; if (ifa.task2b_done_flag !== 1'b1 || dcnt_a != 3) begin n_fail++; $display("FAIL hs_rerun: got flag %b dec writes %0d want 1 and 3", ifa.task2b_done_flag, dcnt_a); end
        for (int n = 0; n < 3; n++) begin
            n_checks++; if (dec_a[n] !== exp[n]) begin n_fail++; $display("FAIL hs_rerun_dec[%0d]: got %h want %h", n, dec_a[n], exp[n]); end
        end
        $display("handshake: rerun dec=%h %h %h", dec_a[0], dec_a[1], dec_a[2]);
        end_run_a();
    endtask

    task automatic test_reset_midrun();
        int cyc;
        setup_small(8'h00, 8'h00, 8'h00);
        ifa.start_task2b = 1'b1;
        // Edge 1 samples start; 16 more edges reach byte 1 WT_J (j = 3).
        repeat (17) @(posedge clk);
        @(negedge clk);
        n_checks++; if (ifa.s_address !== 8'h03) begin n_fail++; $display("FAIL midrun_wtj_addr: got %h want 03", ifa.s_address); end
        reset = 1'b0;
        #1;
        n_checks++; if ({ifa.s_address, ifa.s_data, ifa.dec_data} !== 24'h0) begin n_fail++; $display("FAIL midrun_reset_data: got %h %h %h want 00 00 00", ifa.s_address, ifa.s_data, ifa.dec_data); end
        n_checks++; if ({ifa.s_wren, ifa.dec_wren, ifa.task2b_done_flag} !== 3'b000 || {ifa.rom_address, ifa.dec_address} !== '0) begin
            n_fail++; $display("FAIL midrun_reset_ctrl: got wren %b%b flag %b rom %h dec %h want all 0", ifa.s_wren, ifa.dec_wren, ifa.task2b_done_flag, ifa.rom_address, ifa.dec_address); end
        n_checks++; if (dec_a[0] !== 8'h02 || dec_a[1] !== 8'hEE) begin n_fail++; $display("FAIL midrun_partial: got dec0=%h dec1=%h want 02 EE", dec_a[0], dec_a[1]); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wait_done(1'b0, 200, cyc);
        n_checks++; if (cyc != 36 || ifa.task2b_done_flag !== 1'b1) begin n_fail++; $display("FAIL midrun_restart_latency: got %0d (flag %b) want 36", cyc, ifa.task2b_done_flag); end
        n_checks++; if ({dec_a[0], dec_a[1], dec_a[2]} !== 24'h020507) begin n_fail++; $display("FAIL midrun_restart_dec: got %h %h %h want 02 05 07", dec_a[0], dec_a[1], dec_a[2]); end
        n_checks++; if ({s_a[2], s_a[3], s_a[5]} !== 24'h030502) begin n_fail++; $display("FAIL midrun_restart_S: got %h %h %h want 03 05 02", s_a[2], s_a[3], s_a[5]); end
        $display("reset mid-run: restart dec=%h %h %h", dec_a[0], dec_a[1], dec_a[2]);
        end_run_a();
    endtask

    // Reference RC4: key schedule with key 00 02 49, then 32 keystream bytes.
    task automatic build_full_vectors();
        logic [7:0] s [256];
        logic [7:0] key [3];
        logic [7:0] j, t, ii;
        key = '{8'h00, 8'h02, 8'h49};
        for (int n = 0; n < 256; n++) s[n] = 8'(n);
        j = 8'h00;
        for (int n = 0; n < 256; n++) begin
            j = 8'(j + s[n] + key[n % 3]);
            t = s[n]; s[n] = s[j]; s[j] = t;
        end
        for (int n = 0; n < 256; n++) s_init[n] = s[n];
        ii = 8'h00; j = 8'h00;
        for (int n = 0; n < 32; n++) begin
            ii = 8'(ii + 8'd1);
            j  = 8'(j + s[ii]);
            t = s[ii]; s[ii] = s[j]; s[j] = t;
            rom_init[n] = 8'(n * 29 + 7);
            exp_full[n] = s[8'(s[ii] + s[j])] ^ rom_init[n];
        end
        for (int n = 0; n < 256; n++) exp_s_full[n] = s[n];
    endtask

    task automatic test_full_length();
        int cyc, bad;
        build_full_vectors();
        @(negedge clk); ld_b = 1'b1;
        @(negedge clk); ld_b = 1'b0;
        ifb.start_task2b = 1'b1;
        wait_done(1'b1, 600, cyc);
        n_checks++; if (cyc != 384 || ifb.task2b_done_flag !== 1'b1) begin n_fail++; $display("FAIL full_latency: got %0d (flag %b) want 384", cyc, ifb.task2b_done_flag); end
        for (int n = 0; n < 32; n++) begin
            n_checks++; if (dec_b[n] !== exp_full[n]) begin n_fail++; $display("FAIL full_dec[%0d]: got %h want %h", n, dec_b[n], exp_full[n]); end
        end
        bad = 0;
        for (int n = 0; n < 256; n++) if (s_b[n] !== exp_s_full[n]) bad++;
        n_checks++; if (bad != 0 || dcnt_b != 32) begin n_fail++; $display("FAIL full_S_state: got %0d differing S entries, %0d dec writes want 0 and 32", bad, dcnt_b); end
        $display("run full-length: %0d bytes, latency=%0d", dcnt_b, cyc);
        @(negedge clk); ifb.start_task2b = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        ifa.start_task2b = 1'b0;
        ifb.start_task2b = 1'b0;
        test_reset();
        test_identity_zero_rom();
        test_i_eq_j();
        test_latency_rom();
        test_handshake();
        test_reset_midrun();
        test_full_length();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
